cpu_mem_responder: RTL and testbench

CPU_MEM_RESPONDER -- requirements
Module: cpu_mem_responder

---
 rtl/cpu_mem_responder.sv | 150 +++++++++++++++
 tb/tb_cpu_mem_responder.sv | 421 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_mem_responder.sv
// Single-ported word memory that answers CPU fetch and data requests,
// one transaction at a time, with a fixed response latency.
module cpu_mem_responder #(
    parameter int MEM_WORDS = 256,
    parameter int LATENCY   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] PC,
    input  logic        Inst_Req_Valid,
    output logic        Inst_Req_Ready,
    output logic [31:0] Instruction,
    output logic        Inst_Valid,
    input  logic        Inst_Ready,
    input  logic [31:0] Address,
    input  logic        MemWrite,
    input  logic [31:0] Write_data,
    input  logic [3:0]  Write_strb,
    input  logic        MemRead,
    output logic        Mem_Req_Ready,
    output logic [31:0] Read_data,
    output logic        Read_data_Valid,
    input  logic        Read_data_Ready
);

    localparam int AW = $clog2(MEM_WORDS);
    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_I,
        WAIT_D,
        RESP_I,
        RESP_D
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] data_q, data_d;
    logic        en_q;

    logic [31:0] mem_q [MEM_WORDS];

    logic          dreq;
    logic          idle;
    logic          wr_acc;
    logic          rd_acc;
    logic          i_acc;
    logic [AW-1:0] daddr;
    logic [AW-1:0] iaddr;
    logic          unused_addr;

    assign dreq  = MemRead | MemWrite;
    assign idle  = (state_q == IDLE) && en_q;
    assign daddr = Address[AW+1:2];
    assign iaddr = PC[AW+1:2];

    // Upper address bits alias onto the array; byte offset is ignored.
    assign unused_addr = ^{Address[31:AW+2], Address[1:0],
                           PC[31:AW+2], PC[1:0]};

    // Data requests win over fetches when both are presented.
    assign Mem_Req_Ready  = idle;
    assign Inst_Req_Ready = idle & ~dreq;

    assign wr_acc = Mem_Req_Ready & MemWrite;
    assign rd_acc = Mem_Req_Ready & MemRead & ~MemWrite;
    assign i_acc  = Inst_Req_Ready & Inst_Req_Valid;

    assign Inst_Valid      = (state_q == RESP_I);
    assign Read_data_Valid = (state_q == RESP_D);
    assign Instruction     = Inst_Valid ? data_q : 32'h0;
    assign Read_data       = Read_data_Valid ? data_q : 32'h0;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        unique case (state_q)
            IDLE: begin
                if (rd_acc) begin
                    data_d  = mem_q[daddr];
                    cnt_d   = LAT_M1;
                    state_d = (LATENCY == 1) ? RESP_D : WAIT_D;
                end else if (i_acc) begin
                    data_d  = mem_q[iaddr];
                    cnt_d   = LAT_M1;
                    state_d = (LATENCY == 1) ? RESP_I : WAIT_I;
                end
            end
            WAIT_I: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    cnt_d   = 4'd0;
                    state_d = RESP_I;
                end
            end
            WAIT_D: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    cnt_d   = 4'd0;
                    state_d = RESP_D;
                end
            end
            RESP_I: begin
                if (Inst_Ready) begin
                    state_d = IDLE;
                    data_d  = 32'h0;
                end
            end
            RESP_D: begin
                if (Read_data_Ready) begin
                    state_d = IDLE;
                    data_d  = 32'h0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
                data_d  = 32'h0;
            end
        endcase
    end

    // en_q holds the readies low until the first edge after reset release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            data_q  <= 32'h0;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            en_q    <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            for (int b = 0; b < 4; b++) begin
                if (Write_strb[b]) begin
                    mem_q[daddr][8*b +: 8] <= Write_data[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Directed bench for cpu_mem_responder at default parameters.
module tb_cpu_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] PC;
    logic        Inst_Req_Valid;
    logic        Inst_Req_Ready;
    logic [31:0] Instruction;
    logic        Inst_Valid;
    logic        Inst_Ready;
    logic [31:0] Address;
    logic        MemWrite;
    logic [31:0] Write_data;
    logic [3:0]  Write_strb;
    logic        MemRead;
    logic        Mem_Req_Ready;
    logic [31:0] Read_data;
    logic        Read_data_Valid;
    logic        Read_data_Ready;

    int vec = 0;
    int err = 0;

    always #5 clk = ~clk;

    cpu_mem_responder #(.MEM_WORDS(256), .LATENCY(2)) dut (
        .clk             (clk),
        .rst             (rst),
        .PC              (PC),
        .Inst_Req_Valid  (Inst_Req_Valid),
        .Inst_Req_Ready  (Inst_Req_Ready),
        .Instruction     (Instruction),
        .Inst_Valid      (Inst_Valid),
        .Inst_Ready      (Inst_Ready),
        .Address         (Address),
        .MemWrite        (MemWrite),
        .Write_data      (Write_data),
        .Write_strb      (Write_strb),
        .MemRead         (MemRead),
        .Mem_Req_Ready   (Mem_Req_Ready),
        .Read_data       (Read_data),
        .Read_data_Valid (Read_data_Valid),
        .Read_data_Ready (Read_data_Ready)
    );

    task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s);
        int n;
        @(negedge clk);
        Address = a; Write_data = d; Write_strb = s; MemWrite = 1'b1;
        n = 0;
        while (!Mem_Req_Ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!Mem_Req_Ready) begin
            vec++; err++;
            $display("FAIL write_accept_timeout addr=%h", a);
        end
        @(posedge clk); #1;
        MemWrite = 1'b0; Write_strb = 4'h0;
    endtask

    // lat counts clock edges from the accept edge (inclusive) to the
    // edge at which valid is first seen high.
    task automatic do_read(input logic [31:0] a, output logic [31:0] d,
                           output int lat);
        int n;
        @(negedge clk);
        Address = a; MemRead = 1'b1;
        n = 0;
        while (!Mem_Req_Ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk); #1;
        MemRead = 1'b0;
        lat = 1;
        while (!Read_data_Valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        d = Read_data;
        if (!Read_data_Valid) begin
            vec++; err++;
            $display("FAIL read_timeout addr=%h", a);
        end
        Read_data_Ready = 1'b1;
        @(posedge clk); #1;
        Read_data_Ready = 1'b0;
    endtask

    task automatic do_fetch(input logic [31:0] a, output logic [31:0] d,
                            output int lat);
        int n;
        @(negedge clk);
        PC = a; Inst_Req_Valid = 1'b1;
        n = 0;
        while (!Inst_Req_Ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk); #1;
        Inst_Req_Valid = 1'b0;
        lat = 1;
        while (!Inst_Valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        d = Instruction;
        if (!Inst_Valid) begin
            vec++; err++;
            $display("FAIL fetch_timeout pc=%h", a);
        end
        Inst_Ready = 1'b1;
        @(posedge clk); #1;
        Inst_Ready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        #1 rst = 1'b1;
        #1;
        vec++;
        if ({Mem_Req_Ready, Inst_Req_Ready, Read_data_Valid, Inst_Valid} !== 4'b0) begin
            err++;
            $display("FAIL reset_flags got=%b exp=0000",
                     {Mem_Req_Ready, Inst_Req_Ready, Read_data_Valid, Inst_Valid});
        end
        vec++;
        if (Read_data !== 32'h0 || Instruction !== 32'h0) begin
            err++;
            $display("FAIL reset_data rd=%h inst=%h exp=0", Read_data, Instruction);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        vec++;
        if (Mem_Req_Ready !== 1'b0) begin
            err++;
            $display("FAIL ready_before_edge got=%b exp=0", Mem_Req_Ready);
        end
        @(posedge clk); #1;
        vec++;
        if (Mem_Req_Ready !== 1'b1 || Inst_Req_Ready !== 1'b1) begin
            err++;
            $display("FAIL ready_after_release got=%b%b exp=11",
                     Mem_Req_Ready, Inst_Req_Ready);
        end
    endtask

    task automatic test_write_read;
        logic [31:0] d;
        int lat;
        do_write(32'h10, 32'hDEADBEEF, 4'hF);
        do_read(32'h10, d, lat);
        vec++;
        if (lat !== 2) begin
            err++;
            $display("FAIL read_latency got=%0d exp=2", lat);
        end
        vec++;
        if (d !== 32'hDEADBEEF) begin
            err++;
            $display("FAIL read_data got=%h exp=deadbeef", d);
        end
        vec++;
        if (Read_data !== 32'h0 || Read_data_Valid !== 1'b0) begin
            err++;
            $display("FAIL read_idle_zero got=%h v=%b exp=0", Read_data, Read_data_Valid);
        end
    endtask

    task automatic test_strobe;
        logic [31:0] d;
        int lat;
        do_write(32'h20, 32'h11223344, 4'hF);
        do_write(32'h20, 32'h0000AA00, 4'h2);
        do_read(32'h20, d, lat);
        vec++;
        if (d !== 32'h1122AA44) begin
            err++;
            $display("FAIL strb_byte1 got=%h exp=1122aa44", d);
        end
        do_write(32'h20, 32'hFFFFFFFF, 4'h0);
        do_read(32'h20, d, lat);
        vec++;
        if (d !== 32'h1122AA44) begin
            err++;
            $display("FAIL strb_zero got=%h exp=1122aa44", d);
        end
        do_write(32'h24, 32'hAABBCCDD, 4'hF);
        do_write(32'h24, 32'h11000022, 4'h9);
        do_read(32'h24, d, lat);
        vec++;
        if (d !== 32'h11BBCC22) begin
            err++;
            $display("FAIL strb_edges got=%h exp=11bbcc22", d);
        end
        do_read(32'h13, d, lat);
        vec++;
        if (d !== 32'hDEADBEEF) begin
            err++;
            $display("FAIL byte_offset_ignored got=%h exp=deadbeef", d);
        end
    endtask

    task automatic test_priority;
        int n;
        @(negedge clk);
        Address = 32'h10; MemRead = 1'b1;
        PC = 32'h10; Inst_Req_Valid = 1'b1;
        #1;
        vec++;
        if (Mem_Req_Ready !== 1'b1 || Inst_Req_Ready !== 1'b0) begin
            err++;
            $display("FAIL prio_readies got=%b%b exp=10", Mem_Req_Ready, Inst_Req_Ready);
        end
        @(posedge clk); #1;
        MemRead = 1'b0;
        vec++;
        if (Inst_Req_Ready !== 1'b0) begin
            err++;
            $display("FAIL prio_fetch_blocked got=%b exp=0", Inst_Req_Ready);
        end
        n = 0;
        while (!Read_data_Valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        vec++;
        if (Read_data_Valid !== 1'b1 || Read_data !== 32'hDEADBEEF) begin
            err++;
            $display("FAIL prio_data got=%h v=%b exp=deadbeef", Read_data, Read_data_Valid);
        end
        Read_data_Ready = 1'b1;
        @(posedge clk); #1;
        Read_data_Ready = 1'b0;
        vec++;
        if (Inst_Req_Ready !== 1'b1 || Inst_Valid !== 1'b0) begin
            err++;
            $display("FAIL prio_bubble got rdy=%b v=%b exp rdy=1 v=0",
                     Inst_Req_Ready, Inst_Valid);
        end
        @(posedge clk); #1;
        Inst_Req_Valid = 1'b0;
        vec++;
        if (Inst_Req_Ready !== 1'b0) begin
            err++;
            $display("FAIL prio_fetch_accept got=%b exp=0", Inst_Req_Ready);
        end
        n = 0;
        while (!Inst_Valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        vec++;
        if (Inst_Valid !== 1'b1 || Instruction !== 32'hDEADBEEF) begin
            err++;
            $display("FAIL prio_inst got=%h v=%b exp=deadbeef", Instruction, Inst_Valid);
        end
        Inst_Ready = 1'b1;
        @(posedge clk); #1;
        Inst_Ready = 1'b0;
    endtask

    task automatic test_backpressure;
        int n;
        @(negedge clk);
        PC = 32'h20; Inst_Req_Valid = 1'b1;
        @(posedge clk); #1;
        Inst_Req_Valid = 1'b0;
        n = 0;
        while (!Inst_Valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        Address = 32'h10; MemRead = 1'b1; Inst_Req_Valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            vec++;
            if (Inst_Valid !== 1'b1 || Instruction !== 32'h1122AA44) begin
                err++;
                $display("FAIL hold_inst cyc=%0d got=%h v=%b exp=1122aa44",
                         i, Instruction, Inst_Valid);
            end
            vec++;
            if (Mem_Req_Ready !== 1'b0 || Inst_Req_Ready !== 1'b0) begin
                err++;
                $display("FAIL hold_readies cyc=%0d got=%b%b exp=00",
                         i, Mem_Req_Ready, Inst_Req_Ready);
            end
        end
        MemRead = 1'b0; Inst_Req_Valid = 1'b0;
        Inst_Ready = 1'b1;
        @(posedge clk); #1;
        Inst_Ready = 1'b0;
        vec++;
        if (Inst_Valid !== 1'b0 || Instruction !== 32'h0) begin
            err++;
            $display("FAIL hold_release got=%h v=%b exp=0", Instruction, Inst_Valid);
        end
    endtask

    task automatic test_wrap;
        logic [31:0] d;
        int lat;
        do_write(32'h0, 32'hCAFEF00D, 4'hF);
        do_fetch(32'h400, d, lat);
        vec++;
        if (d !== 32'hCAFEF00D) begin
            err++;
            $display("FAIL fetch_wrap got=%h exp=cafef00d", d);
        end
        vec++;
        if (lat !== 2) begin
            err++;
            $display("FAIL fetch_latency got=%0d exp=2", lat);
        end
        do_write(32'h804, 32'h13579BDF, 4'hF);
        do_read(32'h4, d, lat);
        vec++;
        if (d !== 32'h13579BDF) begin
            err++;
            $display("FAIL write_wrap got=%h exp=13579bdf", d);
        end
    endtask

    task automatic test_rw_both;
        logic [31:0] d;
        int lat;
        @(negedge clk);
        Address = 32'h50; Write_data = 32'h77; Write_strb = 4'hF;
        MemWrite = 1'b1; MemRead = 1'b1;
        @(posedge clk); #1;
        MemWrite = 1'b0; MemRead = 1'b0; Write_strb = 4'h0;
        for (int i = 0; i < 4; i++) begin
            vec++;
            if (Read_data_Valid !== 1'b0 || Mem_Req_Ready !== 1'b1) begin
                err++;
                $display("FAIL rw_no_resp cyc=%0d v=%b rdy=%b exp v=0 rdy=1",
                         i, Read_data_Valid, Mem_Req_Ready);
            end
            @(posedge clk); #1;
        end
        do_read(32'h50, d, lat);
        vec++;
        if (d !== 32'h77) begin
            err++;
            $display("FAIL rw_as_write got=%h exp=00000077", d);
        end
    endtask

    task automatic test_reset_mid;
        logic [31:0] d;
        int lat;
        do_write(32'h40, 32'h5A5A1234, 4'hF);
        @(negedge clk);
        Address = 32'h40; MemRead = 1'b1;
        @(posedge clk); #1;
        MemRead = 1'b0;
        Read_data_Ready = 1'b1;
        rst = 1'b1;
        #1;
        vec++;
        if (Read_data_Valid !== 1'b0 || Mem_Req_Ready !== 1'b0 || Inst_Req_Ready !== 1'b0) begin
            err++;
            $display("FAIL mid_reset_outs got v=%b rdy=%b%b exp 0 00",
                     Read_data_Valid, Mem_Req_Ready, Inst_Req_Ready);
        end
        repeat (3) begin
            @(posedge clk); #1;
            vec++;
            if (Read_data_Valid !== 1'b0 || Read_data !== 32'h0) begin
                err++;
                $display("FAIL mid_reset_valid got v=%b d=%h exp 0", Read_data_Valid, Read_data);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        Read_data_Ready = 1'b0;
        @(posedge clk); #1;
        vec++;
        if (Mem_Req_Ready !== 1'b1 || Inst_Req_Ready !== 1'b1 || Read_data_Valid !== 1'b0) begin
            err++;
            $display("FAIL mid_reset_release got rdy=%b%b v=%b exp 11 0",
                     Mem_Req_Ready, Inst_Req_Ready, Read_data_Valid);
        end
        do_read(32'h40, d, lat);
        vec++;
        if (d !== 32'h5A5A1234) begin
            err++;
            $display("FAIL mem_kept_40 got=%h exp=5a5a1234", d);
        end
        do_read(32'h10, d, lat);
        vec++;
        if (d !== 32'hDEADBEEF) begin
            err++;
            $display("FAIL mem_kept_10 got=%h exp=deadbeef", d);
        end
    endtask

    initial begin
        PC = '0; Inst_Req_Valid = 1'b0; Inst_Ready = 1'b0;
        Address = '0; MemWrite = 1'b0; Write_data = '0; Write_strb = '0;
        MemRead = 1'b0; Read_data_Ready = 1'b0;
        test_reset;
        test_write_read;
        test_strobe;
        test_priority;
        test_backpressure;
        test_wrap;
        test_rw_both;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule
